// File: rtl/rob_drain_scheduler_pkg.sv
// Shared constants, FSM encoding and small helpers for the ROB drain scheduler.
// Every table-related width in the scheduler is derived from these values.
package rob_drain_scheduler_pkg;

    localparam int ROW_W    = 11;
    localparam int ROB_WAYS = 8;
    localparam int ENTRIES  = 4;
    localparam int IDX_W    = 2;
    localparam int AGE_MAX  = 15;
    localparam int TIMEOUT  = 64;
    localparam int WD_W     = 7;

    localparam logic [3:0]      WAYS_C    = 4'(ROB_WAYS);
    localparam logic [3:0]      AGE_MAX_C = 4'(AGE_MAX);
    localparam logic [WD_W-1:0] WD_LAST_C = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RETIRE = 3'd4
    } drain_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] low_idx(input logic [ENTRIES-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            r = v[i] ? IDX_W'(i) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/rob_drain_scheduler_pick.sv
// Combinational drain-candidate picker: starving rows first, then full rows,
// then (only while flushing) the fullest row. Ties go to the lowest index.
module rob_sched_pick
    import rob_drain_scheduler_pkg::*;
(
    input  logic [ENTRIES-1:0]       valid,
    input  logic [ENTRIES-1:0][3:0]  cnt,
    input  logic [ENTRIES-1:0][3:0]  age,
    input  logic                     flush,
    output logic                     found,
    output logic [IDX_W-1:0]         idx
);

    logic [ENTRIES-1:0] age_vec_s;
    logic [ENTRIES-1:0] full_vec_s;
    logic [3:0]         fl_best_s;
    logic [IDX_W-1:0]   fl_idx_s;
    logic               take_s;

    // Candidate vectors plus a running "largest count" scan for flush.
    always_comb begin
        age_vec_s  = '0;
        full_vec_s = '0;
        fl_best_s  = 4'd0;
        fl_idx_s   = '0;
        take_s     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            age_vec_s[i]  = valid[i] && (age[i] == AGE_MAX_C);
            full_vec_s[i] = valid[i] && (cnt[i] == WAYS_C);
            // Strict compare keeps the lowest index on equal counts.
            take_s        = valid[i] && (cnt[i] > fl_best_s);
            fl_idx_s      = take_s ? IDX_W'(i) : fl_idx_s;
            fl_best_s     = take_s ? cnt[i] : fl_best_s;
        end
    end

    // Priority selection between the three trigger classes.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        if (|age_vec_s) begin
            found = 1'b1;
            idx   = low_idx(age_vec_s);
        end else if (|full_vec_s) begin
            found = 1'b1;
            idx   = low_idx(full_vec_s);
        end else if (flush && (|valid)) begin
            found = 1'b1;
            idx   = fl_idx_s;
        end else begin
            found = 1'b0;
            idx   = '0;
        end
    end

endmodule

// File: rtl/rob_drain_scheduler.sv
// Row-tracking table and drain FSM: picks a pending DRAM row, strobes one ROB
// read for it, counts the returning burst and retires the row (or times out).
module rob_drain_scheduler
    import rob_drain_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             iReqValid,
    input  logic [ROW_W-1:0] iReqRow,
    output logic             oReqReady,
    input  logic             iFlush,
    output logic             oROB_Rd,
    output logic [ROW_W-1:0] oROB_Row,
    input  logic             iItemValid,
    input  logic             iItemEnd,
    output logic [3:0]       oDrainCnt,
    output logic             oDrainDone,
    output logic             oErr,
    output logic             oFull,
    output logic             oEmpty
);

    logic [ENTRIES-1:0]            valid_r;
    logic [ENTRIES-1:0][ROW_W-1:0] row_r;
    logic [ENTRIES-1:0][3:0]       cnt_r;
    logic [ENTRIES-1:0][3:0]       age_r;

    drain_state_e     state_r, state_nxt_s;
    logic [IDX_W-1:0] sel_idx_r;
    logic [ROW_W-1:0] row_out_r;
    logic [WD_W-1:0]  wd_r;
    logic [3:0]       drain_cnt_r;
    logic             rd_r, done_r, err_r;

    logic             hit_s, locked_s, full_s, ready_s, accept_s, timeout_s;
    logic             pick_found_s;
    logic [IDX_W-1:0] hit_idx_s, free_idx_s, pick_idx_s;

    rob_sched_pick u_pick (
        .valid (valid_r),
        .cnt   (cnt_r),
        .age   (age_r),
        .flush (iFlush),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Row lookup for the incoming request (rows are unique in the table).
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_idx_s = (valid_r[i] && (row_r[i] == iReqRow)) ? IDX_W'(i) : hit_idx_s;
            hit_s     = hit_s | (valid_r[i] && (row_r[i] == iReqRow));
        end
    end

    assign full_s     = &valid_r;
    assign free_idx_s = low_idx(~valid_r);
    assign locked_s   = (state_r != ST_IDLE) && (sel_idx_r == hit_idx_s);
    assign ready_s    = hit_s ? ((cnt_r[hit_idx_s] < WAYS_C) && !locked_s) : !full_s;
    assign accept_s   = iReqValid && ready_s;

    // Table update: retire frees a slot only after this cycle, so a same-cycle
    // miss never lands on the retiring index (it is still valid here).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r <= '0;
            row_r   <= '0;
            cnt_r   <= '0;
            age_r   <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if ((state_r == ST_RETIRE) && (sel_idx_r == IDX_W'(i))) begin
                    valid_r[i] <= 1'b0;
                    cnt_r[i]   <= 4'd0;
                    age_r[i]   <= 4'd0;
                end else if (accept_s && !hit_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i] <= 1'b1;
                    row_r[i]   <= iReqRow;
                    cnt_r[i]   <= 4'd1;
                    age_r[i]   <= 4'd0;
                end else begin
                    cnt_r[i] <= (accept_s && hit_s && (hit_idx_s == IDX_W'(i)))
                                ? cnt_r[i] + 4'd1 : cnt_r[i];
                    age_r[i] <= (valid_r[i] && !((state_r != ST_IDLE) && (sel_idx_r == IDX_W'(i))))
                                ? sat_inc4(age_r[i], AGE_MAX_C) : age_r[i];
                end
            end
        end
    end

    // Drain FSM next state; timeout marks a WAIT exit without iItemEnd.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE:   state_nxt_s = pick_found_s ? ST_SELECT : ST_IDLE;
            ST_SELECT: state_nxt_s = ST_ISSUE;
            ST_ISSUE:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (iItemEnd) begin
                    state_nxt_s = ST_RETIRE;
                end else if (wd_r == WD_LAST_C) begin
                    state_nxt_s = ST_RETIRE;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RETIRE: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state, selection latch, watchdog, beat counter and output strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            sel_idx_r   <= '0;
            row_out_r   <= '0;
            wd_r        <= '0;
            drain_cnt_r <= 4'd0;
            rd_r        <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && pick_found_s) begin
                sel_idx_r <= pick_idx_s;
                row_out_r <= row_r[pick_idx_s];
            end else begin
                sel_idx_r <= sel_idx_r;
                row_out_r <= row_out_r;
            end
            wd_r <= (state_r == ST_WAIT) ? wd_r + 7'd1 : 7'd0;
            if (state_r == ST_ISSUE) begin
                drain_cnt_r <= 4'd0;
            end else if ((state_r == ST_WAIT) && iItemValid && (drain_cnt_r != 4'd15)) begin
                drain_cnt_r <= drain_cnt_r + 4'd1;
            end else begin
                drain_cnt_r <= drain_cnt_r;
            end
            rd_r   <= (state_nxt_s == ST_ISSUE);
            done_r <= (state_nxt_s == ST_RETIRE);
            err_r  <= (state_nxt_s == ST_RETIRE) && timeout_s;
        end
    end

    assign oReqReady  = ready_s;
    assign oROB_Rd    = rd_r;
    assign oROB_Row   = row_out_r;
    assign oDrainCnt  = drain_cnt_r;
    assign oDrainDone = done_r;
    assign oErr       = err_r;
    assign oFull      = full_s;
    assign oEmpty     = (valid_r == '0) && (state_r == ST_IDLE);

endmodule
